// File: rtl/inst_fetch32.sv
// inst_fetch32 - instruction fetch unit for the KLP32 core.
//
// Owns the program counter. It drives a word address into a combinational
// instruction memory and captures each returned word with its byte PC into
// a small prefetch FIFO. Decode drains that FIFO over a valid/ready
// handshake. A branch/jump redirect flushes the FIFO and reloads the PC.
//
// Handshake: a transfer on the out_* side happens in every cycle where
// out_valid and out_ready are both high at the rising edge of clk.
// out_valid, out_inst and out_pc come only from registered state. They do
// not depend combinationally on out_ready. Once out_valid is high, it and
// the head entry stay stable until that entry is popped, a redirect occurs,
// or reset is applied.
//
// Parameters
//   n         data/address width
//   RESET_PC  byte address loaded into the PC on reset
//   DEPTH     prefetch FIFO entries (power of two, 2..8)
//
// Ports
//   clk             sole clock, rising edge
//   rst             synchronous active-high reset
//   imem_addr       word address to instruction memory = {2'b00, pc[n-1:2]}
//   imem_inst       instruction word, combinational from imem_addr
//   fetch_en        1 = fetch allowed, 0 = hold PC and do not push
//   redirect_valid  branch/jump taken this cycle (highest priority)
//   redirect_pc     redirect target byte address (low two bits ignored)
//   out_valid       FIFO head holds a valid instruction
//   out_ready       decode accepts the head this cycle
//   out_inst        head instruction
//   out_pc          byte PC of the head instruction
module inst_fetch32 #(
  parameter int unsigned   n        = 32,
  parameter logic [n-1:0]  RESET_PC = '0,
  parameter int unsigned   DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  output logic [n-1:0] imem_addr,
  input  logic [n-1:0] imem_inst,
  input  logic         fetch_en,
  input  logic         redirect_valid,
  input  logic [n-1:0] redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_inst,
  output logic [n-1:0] out_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [n-1:0]  pc_q;
  logic [n-1:0]  pc_d;
  logic [n-1:0]  inst_mem_q [DEPTH];
  logic [n-1:0]  pc_mem_q   [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] rd_d;
  logic [PW-1:0] wr_q;
  logic [PW-1:0] wr_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic pop;
  logic push;

  // A full FIFO may still accept a push when the head leaves in the same
  // cycle. That keeps one instruction per cycle under steady out_ready.
  assign pop  = out_valid & out_ready;
  assign push = fetch_en & ~redirect_valid & ((count_q != FULL_CNT) | pop);

  assign imem_addr = {2'b00, pc_q[n-1:2]};
  assign out_valid = (count_q != '0);
  assign out_inst  = inst_mem_q[rd_q];
  assign out_pc    = pc_mem_q[rd_q];

  always_comb begin
    pc_d    = pc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (redirect_valid) begin
      // The flush wins over any pop this cycle. Decode still counts that
      // pop as a completed transfer.
      pc_d    = {redirect_pc[n-1:2], 2'b00};
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d = pc_q + n'(4);
        // Pointers wrap naturally because DEPTH is a power of two.
        wr_d = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage has no reset. Entries are only meaningful while count > 0.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      inst_mem_q[wr_q] <= imem_inst;
      pc_mem_q[wr_q]   <= pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch32.sv
// Directed bench for inst_fetch32.
//
// The bench runs two instances:
//   dut    uses RESET_PC = 0
//   dut_w  uses RESET_PC = FFFF_FFF8 to exercise PC wraparound
//
// Each instance reads a memory model in which word address a returns
// 32'h1000_0000 + a.
//
// Inputs change 1 ns after a rising edge. Outputs are sampled at the same
// point, away from the edge.
module tb_inst_fetch32;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  logic        rst_w;
  logic [31:0] imem_addr_w;
  logic [31:0] imem_inst_w;
  logic        out_valid_w;
  logic [31:0] out_inst_w;
  logic [31:0] out_pc_w;

  int checks;
  int errors;

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models.
  assign imem_inst   = 32'h1000_0000 + imem_addr;
  assign imem_inst_w = 32'h1000_0000 + imem_addr_w;

  inst_fetch32 #(.n(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  inst_fetch32 #(.n(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .clk            (clk),
    .rst            (rst_w),
    .imem_addr      (imem_addr_w),
    .imem_inst      (imem_inst_w),
    .fetch_en       (1'b1),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .out_valid      (out_valid_w),
    .out_ready      (1'b1),
    .out_inst       (out_inst_w),
    .out_pc         (out_pc_w)
  );

  // Advance one cycle, then stop 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    rst_w          = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;

    step();
    step();
    chk("reset_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_addr_w", imem_addr_w, 32'h3FFF_FFFE);

    // Streaming with out_ready held high.
    rst       = 1'b0;
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("stream_valid%0d", i), {31'b0, out_valid}, 32'h1);
      chk($sformatf("stream_pc%0d", i), out_pc, 32'(4 * i));
      chk($sformatf("stream_inst%0d", i), out_inst, 32'h1000_0000 + 32'(i));
    end

    // Backpressure from a fresh reset.
    rst = 1'b1;
    step();
    step();
    rst       = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("bp_count", 32'(dut.count_q), 32'd2);
    chk("bp_addr", imem_addr, 32'h2);
    chk("bp_head_pc", out_pc, 32'h0);
    chk("bp_valid", {31'b0, out_valid}, 32'h1);
    out_ready = 1'b1;
    step();
    chk("bp_pc1", out_pc, 32'h4);
    step();
    chk("bp_pc2", out_pc, 32'h8);
    step();
    chk("bp_pc3", out_pc, 32'hC);
    chk("bp_full_count", 32'(dut.count_q), 32'd2);

    // Redirect while two entries are held. No pop happens this cycle.
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    chk("rd_bubble_valid", {31'b0, out_valid}, 32'h0);
    chk("rd_addr", imem_addr, 32'h40);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    step();
    chk("rd_valid", {31'b0, out_valid}, 32'h1);
    chk("rd_pc", out_pc, 32'h100);
    chk("rd_inst", out_inst, 32'h1000_0040);
    step();
    chk("rd_pc_next", out_pc, 32'h104);

    // A redirect in the same cycle as a pop.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    chk("pr_valid", {31'b0, out_valid}, 32'h0);
    chk("pr_addr", imem_addr, 32'h80);

    // A redirect while fetch_en is low.
    fetch_en       = 1'b0;
    redirect_pc    = 32'h0000_0302;
    step();
    chk("fr_valid", {31'b0, out_valid}, 32'h0);
    chk("fr_addr", imem_addr, 32'hC0);
    redirect_valid = 1'b0;
    step();
    chk("hold_valid", {31'b0, out_valid}, 32'h0);
    chk("hold_addr", imem_addr, 32'hC0);
    fetch_en = 1'b1;
    step();
    chk("fr_out_valid", {31'b0, out_valid}, 32'h1);
    chk("fr_out_pc", out_pc, 32'h300);
    chk("fr_out_inst", out_inst, 32'h1000_00C0);

    // Reset asserted mid-stream while the FIFO is full.
    out_ready = 1'b0;
    step();
    step();
    chk("mid_full_count", 32'(dut.count_q), 32'd2);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    chk("mid_rel_valid", {31'b0, out_valid}, 32'h1);
    chk("mid_rel_pc", out_pc, 32'h0);

    // PC wraparound on the second instance.
    rst_w = 1'b0;
    step();
    chk("wrap_pc0", out_pc_w, 32'hFFFF_FFF8);
    chk("wrap_inst0", out_inst_w, 32'h4FFF_FFFE);
    chk("wrap_addr1", imem_addr_w, 32'h3FFF_FFFF);
    step();
    chk("wrap_pc1", out_pc_w, 32'hFFFF_FFFC);
    chk("wrap_inst1", out_inst_w, 32'h4FFF_FFFF);
    chk("wrap_addr2", imem_addr_w, 32'h0);
    step();
    chk("wrap_valid2", {31'b0, out_valid_w}, 32'h1);
    chk("wrap_pc2", out_pc_w, 32'h0);
    chk("wrap_inst2", out_inst_w, 32'h1000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
